// File: rtl/kof_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// kof_pkg : action encodings, PS/2 prefix bytes and the two-player key map
// Rev 1.0
// ----------------------------------------------------------------------------
package kof_pkg;

  typedef enum logic [1:0] {
    ACT_NONE   = 2'b00,
    ACT_LEFT   = 2'b01,
    ACT_RIGHT  = 2'b10,
    ACT_ATTACK = 2'b11
  } action_t;

  localparam logic [7:0] c_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] c_PREFIX_BRK = 8'hF0;

  localparam logic [7:0] c_P1_LEFT    = 8'h1C;
  localparam logic [7:0] c_P1_RIGHT   = 8'h23;
  localparam logic [7:0] c_P1_ATTACK  = 8'h3B;

  localparam logic [7:0] c_P2_LEFT    = 8'h6B;
  localparam logic [7:0] c_P2_RIGHT   = 8'h74;
  localparam logic [7:0] c_P2_ATTACK  = 8'h75;

  // Extended bytes look up only the P2 map, plain bytes only the P1 map.
  function automatic action_t map_key(input logic [7:0] b, input logic is_ext);
    action_t r;
    r = ACT_NONE;
    if (is_ext) begin
      case (b)
        c_P2_LEFT:   r = ACT_LEFT;
        c_P2_RIGHT:  r = ACT_RIGHT;
        c_P2_ATTACK: r = ACT_ATTACK;
        default:     r = ACT_NONE;
      endcase
    end else begin
      case (b)
        c_P1_LEFT:   r = ACT_LEFT;
        c_P1_RIGHT:  r = ACT_RIGHT;
        c_P1_ATTACK: r = ACT_ATTACK;
        default:     r = ACT_NONE;
      endcase
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_action_scheduler_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// key_action_scheduler_if : scan-code input and per-player action output bus
// Rev 1.0
// ----------------------------------------------------------------------------
interface key_action_scheduler_if;

  logic [7:0] code;
  logic       code_valid;
  logic       tick;
  logic [1:0] p1_action;
  logic [1:0] p2_action;
  logic       action_valid;

  modport master (
    output code, code_valid, tick,
    input  p1_action, p2_action, action_valid
  );

  modport slave (
    input  code, code_valid, tick,
    output p1_action, p2_action, action_valid
  );

endinterface
`default_nettype wire

// File: rtl/player_action.sv
`default_nettype none
// ----------------------------------------------------------------------------
// player_action : held-key tracking, direction resolve and attack cooldown
// Rev 1.0
// ----------------------------------------------------------------------------
module player_action
  import kof_pkg::*;
#(
  parameter int COOLDOWN = 4
)
(
  input  logic    clk,
  input  logic    rst,
  input  logic    i_tick,
  input  action_t i_key,
  input  logic    i_is_break,
  output action_t o_action
);

  localparam logic [3:0] c_COOL_LOAD = 4'(COOLDOWN - 1);

  logic       r_held_left;
  logic       r_held_right;
  logic       r_held_attack;
  action_t    r_last_dir;
  logic [3:0] r_cool;
  action_t    r_action;

  action_t    w_dir;
  action_t    w_next_action;
  logic       w_fire;

  always_comb begin
    w_dir = ACT_NONE;
    if (r_held_left && r_held_right) w_dir = r_last_dir;
    else if (r_held_left)            w_dir = ACT_LEFT;
    else if (r_held_right)           w_dir = ACT_RIGHT;
    w_fire        = r_held_attack && (r_cool == 4'd0);
    w_next_action = w_fire ? ACT_ATTACK : w_dir;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_held_left   <= 1'b0;
      r_held_right  <= 1'b0;
      r_held_attack <= 1'b0;
      r_last_dir    <= ACT_LEFT;
      r_cool        <= 4'd0;
      r_action      <= ACT_NONE;
    end else begin
      case (i_key)
        ACT_LEFT: begin
          r_held_left <= !i_is_break;
          if (!i_is_break) r_last_dir <= ACT_LEFT;
        end
        ACT_RIGHT: begin
          r_held_right <= !i_is_break;
          if (!i_is_break) r_last_dir <= ACT_RIGHT;
        end
        ACT_ATTACK: r_held_attack <= !i_is_break;
        default: ;
      endcase
      // Tick samples the held state from before this edge; a same-cycle key waits.
      if (i_tick) begin
        r_action <= w_next_action;
        if (w_fire)              r_cool <= c_COOL_LOAD;
        else if (r_cool != 4'd0) r_cool <= r_cool - 4'd1;
      end
    end
  end

  assign o_action = r_action;

endmodule
`default_nettype wire

// File: rtl/scan_parser.sv
`default_nettype none
// ----------------------------------------------------------------------------
// scan_parser : PS/2 E0/F0 prefix tracker, flags each completed make or break
// Rev 1.0
// ----------------------------------------------------------------------------
module scan_parser
  import kof_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_code,
  input  logic       i_code_valid,
  output logic       o_done,
  output logic       o_is_break,
  output logic       o_is_ext,
  output logic [7:0] o_byte
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_done      = 1'b0;
    o_is_break  = 1'b0;
    o_is_ext    = 1'b0;
    o_byte      = i_code;
    if (i_code_valid) begin
      if (i_code == c_PREFIX_BRK) begin
        w_state_nxt = (r_state == EXT || r_state == EXT_BRK) ? EXT_BRK : BRK;
      end else if (i_code == c_PREFIX_EXT && r_state != EXT) begin
        // A fresh E0 drops any pending break and starts a new extended code.
        w_state_nxt = EXT;
      end else begin
        w_state_nxt = IDLE;
        o_done      = 1'b1;
        o_is_break  = (r_state == BRK) || (r_state == EXT_BRK);
        o_is_ext    = (r_state == EXT) || (r_state == EXT_BRK);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/key_action_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// key_action_scheduler : turns PS/2 scan codes into per-frame two-player actions
// Rev 1.0
// ----------------------------------------------------------------------------
module key_action_scheduler
  import kof_pkg::*;
#(
  parameter int COOLDOWN = 4
)
(
  input  logic                  clk,
  input  logic                  rst,
  key_action_scheduler_if.slave bus
);

  logic       w_done;
  logic       w_is_break;
  logic       w_is_ext;
  logic [7:0] w_byte;
  action_t    w_mapped;
  action_t    w_key [2];
  action_t    w_action [2];
  logic       r_action_valid;

  scan_parser u_parser (
    .clk          (clk),
    .rst          (rst),
    .i_code       (bus.code),
    .i_code_valid (bus.code_valid),
    .o_done       (w_done),
    .o_is_break   (w_is_break),
    .o_is_ext     (w_is_ext),
    .o_byte       (w_byte)
  );

  always_comb begin
    w_mapped = w_done ? map_key(w_byte, w_is_ext) : ACT_NONE;
    w_key[0] = w_is_ext ? ACT_NONE : w_mapped;
    w_key[1] = w_is_ext ? w_mapped : ACT_NONE;
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_player
      player_action #(
        .COOLDOWN (COOLDOWN)
      ) u_player (
        .clk        (clk),
        .rst        (rst),
        .i_tick     (bus.tick),
        .i_key      (w_key[gi]),
        .i_is_break (w_is_break),
        .o_action   (w_action[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_action_valid <= 1'b0;
    else     r_action_valid <= bus.tick;
  end

  assign bus.p1_action    = w_action[0];
  assign bus.p2_action    = w_action[1];
  assign bus.action_valid = r_action_valid;

endmodule
`default_nettype wire
